// File: rtl/ieee_itof.sv
// Converts a 32-bit signed/unsigned integer to IEEE-754 single precision, round-to-nearest-even;
// latency 1 cycle for zero else lz+3 after accept; one operand in flight, result held in DONE until out_ready.
module ieee_itof (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_out_data;
    logic        r_inexact;

    logic        w_accept;
    logic        w_sign_in;
    logic [31:0] w_mag_in;
    logic        w_mag_zero;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_rnd_up;
    logic [23:0] w_mant_sum;
    logic [7:0]  w_exp_rnd;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign inexact   = r_inexact;

    assign w_accept   = in_valid && in_ready;
    assign w_sign_in  = in_signed & in_data[31];
    // Negating 0x80000000 wraps to itself, which is already the correct magnitude 2^31.
    assign w_mag_in   = w_sign_in ? (32'd0 - in_data) : in_data;
    assign w_mag_zero = (w_mag_in == 32'd0);

    assign w_mant     = r_mag[30:8];
    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_rnd_up   = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_rnd_up};
    // A carry out leaves the low 23 bits at zero, so only the exponent needs adjusting.
    assign w_exp_rnd  = r_exp + {7'd0, w_mant_sum[23]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_mag_zero ? DONE : NORM;
                end
            end
            NORM: begin
                if (r_mag[31]) begin
                    w_state_nxt = ROUND;
                end
            end
            ROUND: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign     <= 1'b0;
            r_mag      <= 32'd0;
            r_exp      <= 8'd0;
            r_out_data <= 32'd0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_mag_in;
                        r_exp  <= 8'd158;
                        if (w_mag_zero) begin
                            r_out_data <= 32'd0;
                            r_inexact  <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ROUND: begin
                    r_out_data <= {r_sign, w_exp_rnd, w_mant_sum[22:0]};
                    r_inexact  <= w_guard | w_sticky;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_itof.sv
// Scoreboard bench for ieee_itof: randomized and directed operands checked against an arithmetic reference model.
module tb_ieee_itof;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        inexact;

    typedef struct {
        logic [31:0] d;
        logic        inx;
        int          lat;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   first_cyc;
    logic hold   = 1'b0;
    logic prev_valid = 1'b0;

    ieee_itof dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer changes out_ready shortly after the rising edge so the monitor sees a settled value.
    always @(posedge clk) begin
        #2;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference conversion from the value's magnitude using plain 64-bit arithmetic.
    function automatic exp_t model(input logic [31:0] d, input logic s);
        exp_t        r;
        logic        neg;
        longint      v, q, rem, half;
        int          e, sh, lz;
        logic [63:0] qb;
        neg = s && d[31];
        v   = longint'({32'd0, d});
        if (neg) v = 64'sd4294967296 - v;
        r.n = 0;
        if (v == 0) begin
            r.d = 32'd0; r.inx = 1'b0; r.lat = 1;
            return r;
        end
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        lz  = 31 - e;
        rem = 0;
        if (e <= 23) begin
            q = v << (23 - e);
        end else begin
            sh   = e - 23;
            q    = v >> sh;
            rem  = v - (q << sh);
            half = longint'(64'd1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(64'd1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        qb    = q;
        r.d   = {neg, 8'(e + 127), qb[22:0]};
        r.inx = (rem != 0);
        r.lat = lz + 3;
        return r;
    endfunction

    // Monitor: every DONE cycle is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_valid 1 with no operand outstanding (cycle %0d)", cyc);
                end else begin
                    if (!prev_valid) begin
                        first_cyc = cyc;
                        chk("latency", 32'(first_cyc - sb[0].n), 32'(sb[0].lat));
                    end
                    chk("out_data", out_data, sb[0].d);
                    chk("inexact", {31'd0, inexact}, {31'd0, sb[0].inx});
                    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [31:0] d, input logic s, input exp_t e);
        int t;
        t = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready 0, required 1 within 200 cycles");
        end else begin
            e.n = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = $urandom_range(0, 1);
    endtask

    task automatic send_dir(input logic [31:0] d, input logic s, input logic [31:0] rd,
                            input logic rinx, input int lat);
        exp_t e;
        e.d = rd; e.inx = rinx; e.lat = lat; e.n = 0;
        send(d, s, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding results, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        s;
        int          t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_inexact", {31'd0, inexact}, 32'd0);
        rst = 1'b0;

        send_dir(32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34);
        send_dir(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34);
        send_dir(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3);
        send_dir(32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10);
        send_dir(32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10);
        send_dir(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3);
        send_dir(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1);
        send_dir(32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1);
        drain();

        // Back-pressure: consumer stalls for 10 cycles once the result is up.
        hold = 1'b1;
        send_dir(32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10);
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_data", out_data, 32'h4B80_0002);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        hold = 1'b0;
        drain();

        // Reset while the operand is still normalising: nothing may come out.
        send(32'h0000_0001, 1'b0, model(32'h0000_0001, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_reset_out_data", out_data, 32'd0);
        repeat (40) @(negedge clk);
        chk("post_reset_quiet", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: d = $urandom_range(0, 255);
                1: d = 32'd1 << $urandom_range(0, 31);
                2: d = 32'hFFFF_FFFF - $urandom_range(0, 300);
                3: d = ($urandom | 32'h0100_0000) & 32'h01FF_FFFF;
                default: d = $urandom;
            endcase
            s = $urandom_range(0, 1);
            send(d, s, model(d, s));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ieee_itof.md
IEEE_ITOF -- requirements
Module: ieee_itof

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port clk, input, 1 bit: sole clock.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: an operand is offered on in_data/in_signed.
REQ-005 Port in_ready, output, 1 bit: the block can accept an operand; equals 1 exactly when state = IDLE.
REQ-006 Port in_data, input, 32 bits: integer operand.
REQ-007 Port in_signed, input, 1 bit: 1 = two's-complement operand, 0 = unsigned operand.
REQ-008 Port out_valid, output, 1 bit: out_data/inexact hold a valid result.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 Port out_data, output, 32 bits: IEEE-754 single-precision result, in the operand format consumed by the team's float ALU.
REQ-011 Port inexact, output, 1 bit: the result was rounded (guard or sticky nonzero).

Function
REQ-012 An operand SHALL be accepted only in a cycle where in_valid = 1 and in_ready = 1; in_data and in_signed SHALL be captured at that edge and ignored afterwards.
REQ-013 At capture: sign = in_signed & in_data[31]; mag = sign ? (0 - in_data) mod 2^32 : in_data; exp = 158; magnitude 0x80000000 from signed -2^31 SHALL be handled without a special case.
REQ-014 States SHALL be IDLE, NORM, ROUND, DONE; reset state IDLE.
REQ-015 IDLE: on accept with mag = 0, go to DONE with out_data = 0x00000000 and inexact = 0 (no -0 is ever produced); on accept with mag != 0, go to NORM.
REQ-016 NORM: while mag[31] = 0, mag <<= 1 and exp -= 1, one bit per cycle; when mag[31] = 1, go to ROUND; leading-zero count lz (0..31) is therefore resolved in lz+1 NORM cycles.
REQ-017 ROUND: mant = mag[30:8], guard = mag[7], sticky = |mag[6:0]; round to nearest, ties to even: increment mant when guard & (sticky | mant[0]).
REQ-018 ROUND: on mantissa carry-out, mant = 0 and exp += 1; exp SHALL never exceed 159, so overflow and underflow are impossible and are not reported.
REQ-019 ROUND: register out_data = {sign, exp[7:0], mant} and inexact = guard | sticky, then go to DONE.
REQ-020 DONE: out_valid = 1; out_data and inexact SHALL stay stable until a cycle with out_ready = 1, after which the state returns to IDLE; back-pressure of any length SHALL be tolerated.
REQ-021 Latency, with accept in cycle N: out_valid first high in cycle N+1 for zero input and in cycle N+lz+3 otherwise; there is one operand in flight at most, with no overlap.
REQ-022 in_ready SHALL be 0 in every non-IDLE state, including the DONE cycle in which out_ready = 1; the next accept is possible one cycle later.
REQ-023 out_valid SHALL be 0 in IDLE, NORM and ROUND.

Reset
REQ-024 With rst = 1 at an edge: state = IDLE, out_valid = 0, out_data = 0x00000000, inexact = 0, internal mag/exp/sign cleared; in_ready = 1 in the following cycle.
REQ-025 rst SHALL take priority over any simultaneous handshake; an operand in flight at reset SHALL be discarded and produce no out_valid pulse.

Verification
REQ-026 Unsigned 0x00000001 -> out_data 0x3F800000, inexact 0, out_valid 34 cycles after accept.
REQ-027 Signed 0xFFFFFFFF (-1) -> 0xBF800000, inexact 0; signed 0x80000000 -> 0xCF000000, inexact 0, latency 3.
REQ-028 Unsigned 0x01000001 (tie, even) -> 0x4B800000, inexact 1; unsigned 0x01000003 (tie, odd) -> 0x4B800002, inexact 1.
REQ-029 Unsigned 0xFFFFFFFF -> mantissa carry-out -> 0x4F800000, inexact 1; signed or unsigned 0 -> 0x00000000, out_valid in cycle N+1.
REQ-030 Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_data stable and in_ready = 0 throughout; assert rst during NORM -> out_valid never rises, in_ready = 1 in the cycle after reset.
